rtdf_rx_packet_framer: RTL
==========================

Name: rtdf_rx_packet_framer

Overview:
- Upstream stage of the real-time data feed packet processor, in the clk_rx domain.
- Takes the raw per-byte receive stream from the Ethernet controller interface and packs it into 16-bit words.
- Holds each frame in a two-bank ping-pong buffer until the frame is complete and checked.
- Writes each good frame to the RX FIFO as one length word followed by the data words; the processor reads this format.

Parameters:
- BANK_WORDS, 1024: words per bank (2048 bytes); the bank address is log2(BANK_WORDS) bits.
- LEN_WIDTH, 11: width of the byte-count field in the length word.
- MIN_BYTES, 64: smallest accepted frame, CRC included.
- MAX_BYTES, 1522: largest accepted frame, CRC included; must not exceed 2*BANK_WORDS.

Ports:
- clk_rx  in  1  receive clock; everything in this block is clocked on it.
- reset  in  1  synchronous, active-high.
- rx_valid  in  1  rx_data holds a byte this cycle.
- rx_data  in  8  received byte, in wire order.
- rx_sop  in  1  first byte of a frame; qualified by rx_valid.
- rx_eop  in  1  last byte of a frame; qualified by rx_valid.
- rx_err  in  1  frame error (CRC or PHY); sampled with rx_eop.
- fifo_full  in  1  write-side full flag of the RX FIFO.
- fifo_wr_req  out  1  write strobe to the RX FIFO.
- fifo_wr_data  out  16  word to the RX FIFO.
- good_count  out  8  frames forwarded; wraps.
- drop_count  out  8  frames discarded; wraps.

Behaviour:
- Reset: both banks empty, both state machines idle, fifo_wr_req=0, fifo_wr_data=0, both counters 0.
- A reset mid-frame or mid-drain abandons the frame; the RX FIFO shares the same reset.

Packing:
- Byte 2k of a frame goes to word k bits [7:0]; byte 2k+1 goes to bits [15:8].
- For an odd byte count, the last word's bits [15:8] are 0.
- Byte count includes the CRC bytes.

Write FSM, states W_IDLE, W_FILL, W_DROP:
- W_IDLE, on rx_valid&rx_sop:
  - if the bank at wr_bank is empty, go to W_FILL with byte_count=1;
  - otherwise go to W_DROP and increment drop_count.
- W_FILL:
  - each rx_valid byte is stored and byte_count is incremented;
  - byte_count reaching MAX_BYTES+1 goes to W_DROP (bank stays empty, drop_count+1).
- rx_eop in W_FILL:
  - if rx_err=1 or byte_count<MIN_BYTES: drop, drop_count+1, return to W_IDLE;
  - otherwise mark the bank full, latch its byte count, toggle wr_bank, return to W_IDLE.
- rx_sop while in W_FILL (missing eop): the current frame is dropped (drop_count+1). The new frame is handled exactly as an rx_sop in W_IDLE.
- W_DROP: ignores bytes until rx_eop, then W_IDLE. An rx_sop in W_DROP is handled exactly as an rx_sop in W_IDLE.
- rx_sop and rx_eop on the same byte: a 1-byte frame, always a runt, so dropped.

Read FSM, states R_IDLE, R_LENGTH, R_DATA:
- R_IDLE: if the bank at rd_bank is full, go to R_LENGTH.
- R_LENGTH: fifo_wr_data = {zeros, byte_count[LEN_WIDTH-1:0]}.
- R_DATA: emits ceil(byte_count/2) words in order.
- Bank RAM has 1-cycle read latency; the prefetch keeps the next word ready, so there are no bubbles while fifo_full=0.
- Handshake: fifo_wr_req = word_ready & !fifo_full (combinational gate). A word is consumed on the edge where fifo_wr_req=1. fifo_wr_data is registered and holds steady while fifo_full=1.
- After the last word is consumed: the bank is marked empty, rd_bank toggles, good_count+1, return to R_IDLE.
- Latency: first fifo_wr_req no later than 3 cycles after the accepting rx_eop when fifo_full=0.
- Simultaneous events: when the write FSM marks one bank full on the same edge the read FSM releases the other, both updates take effect.

Test Plan:
- 64-byte good frame, bytes 0x00..0x3F, fifo_full=0 -> length word 0x0040, then words 0x0100, 0x0302 … 0x3F3E (32 words), good_count=1.
- 65-byte good frame -> length word 0x0041, 33 data words, last word 0x0040.
- 63-byte frame; 100-byte frame with rx_err=1 at eop; 1600-byte frame -> no FIFO writes, drop_count=3.
- Three back-to-back 100-byte frames while fifo_full is held high for 500 cycles:
  - frames 1 and 2 are buffered, frame 3 is dropped (drop_count=1);
  - after release, exactly 2×(1+50) writes occur, in order.
- fifo_full toggled every other cycle during a drain -> no duplicated or skipped words; fifo_wr_req is never high while fifo_full=1.
- reset asserted mid-drain for 1 cycle -> fifo_wr_req=0 on the next cycle, counters 0, next frame is forwarded intact.

Source files
------------

// File: rtl/rtdf_rx_packet_framer.sv
// Receive-side framer: packs the byte stream into 16-bit words and holds each frame in a ping-pong bank.
// Each good frame goes to the RX FIFO as a length word followed by its data words.
module rtdf_rx_packet_framer #(
    parameter int BANK_WORDS = 1024,
    parameter int LEN_WIDTH  = 11,
    parameter int MIN_BYTES  = 64,
    parameter int MAX_BYTES  = 1522
) (
    input  logic        clk_rx,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_err,
    input  logic        fifo_full,
    output logic        fifo_wr_req,
    output logic [15:0] fifo_wr_data,
    output logic [7:0]  good_count,
    output logic [7:0]  drop_count
);
    localparam int AW = $clog2(BANK_WORDS);
    localparam int CW = AW + 2;
    localparam int MW = 2 * BANK_WORDS;

    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_BYTES);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BYTES);
    localparam logic [AW-1:0] IDX_ONE = AW'(1'b1);
    localparam logic [AW-1:0] IDX_TWO = AW'(2'd2);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_LENGTH = 2'd1,
        R_DATA   = 2'd2
    } r_state_t;

    w_state_t      w_state_r;
    w_state_t      w_next_s;
    r_state_t      r_state_r;
    r_state_t      r_next_s;

    logic [1:0]    bank_full_r;
    logic [CW-1:0] bank_len_r [2];
    logic          wr_bank_r;
    logic          rd_bank_r;

    logic [CW-1:0] wr_cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic [AW:0]   mem_idx_s;
    logic          mem_we_s;
    logic          commit_s;
    logic          start_s;
    logic [1:0]    drop_add_s;

    logic [7:0]    mem_lo_r [MW];
    logic [7:0]    mem_hi_r [MW];
    logic [7:0]    ram_lo_r;
    logic [7:0]    ram_hi_r;

    logic [AW-1:0] rd_word_s;
    logic [AW-1:0] ld_idx_s;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] last_idx_r;
    logic [AW-1:0] nwords_s;
    logic          rd_odd_r;
    logic          word_ready_r;
    logic          consume_s;
    logic          load_len_s;
    logic          load_word_s;
    logic          release_s;
    logic [15:0]   wr_data_r;
    logic [7:0]    good_count_r;
    logic [7:0]    drop_count_r;

    assign fifo_wr_req  = word_ready_r & ~fifo_full;
    assign consume_s    = fifo_wr_req;
    assign fifo_wr_data = wr_data_r;
    assign good_count   = good_count_r;
    assign drop_count   = drop_count_r;
    assign nwords_s     = AW'((bank_len_r[rd_bank_r] + CNT_ONE) >> 1);

    // Write FSM next state: byte storage, frame acceptance and drop accounting
    always_comb begin
        w_next_s   = w_state_r;
        cnt_next_s = wr_cnt_r;
        mem_idx_s  = wr_cnt_r[AW:0];
        mem_we_s   = 1'b0;
        commit_s   = 1'b0;
        start_s    = 1'b0;
        drop_add_s = 2'd0;
        case (w_state_r)
            W_IDLE: begin
                if (rx_valid && rx_sop) begin
                    start_s = 1'b1;
                end else begin
                    w_next_s = W_IDLE;
                end
            end
            W_DROP: begin
                if (rx_valid && rx_sop) begin
                    start_s = 1'b1;
                end else if (rx_valid && rx_eop) begin
                    w_next_s = W_IDLE;
                end else begin
                    w_next_s = W_DROP;
                end
            end
            W_FILL: begin
                if (rx_valid && rx_sop) begin
                    // missing eop: abandon the partial frame and restart on this byte
                    drop_add_s = 2'd1;
                    start_s    = 1'b1;
                end else if (rx_valid) begin
                    cnt_next_s = wr_cnt_r + CNT_ONE;
                    if (cnt_next_s > CNT_MAX) begin
                        drop_add_s = 2'd1;
                        if (rx_eop) begin
                            w_next_s = W_IDLE;
                        end else begin
                            w_next_s = W_DROP;
                        end
                    end else begin
                        mem_we_s = 1'b1;
                        if (rx_eop) begin
                            w_next_s = W_IDLE;
                            if (rx_err || (cnt_next_s < CNT_MIN)) begin
                                drop_add_s = 2'd1;
                            end else begin
                                commit_s = 1'b1;
                            end
                        end else begin
                            w_next_s = W_FILL;
                        end
                    end
                end else begin
                    w_next_s = W_FILL;
                end
            end
            default: begin
                w_next_s = W_IDLE;
            end
        endcase

        if (start_s) begin
            if (bank_full_r[wr_bank_r]) begin
                drop_add_s = drop_add_s + 2'd1;
                if (rx_eop) begin
                    w_next_s = W_IDLE;
                end else begin
                    w_next_s = W_DROP;
                end
            end else begin
                mem_we_s   = 1'b1;
                mem_idx_s  = '0;
                cnt_next_s = CNT_ONE;
                if (rx_eop) begin
                    drop_add_s = drop_add_s + 2'd1;
                    w_next_s   = W_IDLE;
                end else begin
                    w_next_s   = W_FILL;
                end
            end
        end else begin
            mem_idx_s = mem_idx_s;
        end
    end

    // Bank ownership, write FSM state and frame counters; commit and release may land on one edge
    always_ff @(posedge clk_rx) begin
        if (reset) begin
            w_state_r     <= W_IDLE;
            wr_cnt_r      <= '0;
            wr_bank_r     <= 1'b0;
            rd_bank_r     <= 1'b0;
            bank_full_r   <= 2'b00;
            bank_len_r[0] <= '0;
            bank_len_r[1] <= '0;
            good_count_r  <= 8'd0;
            drop_count_r  <= 8'd0;
        end else begin
            w_state_r    <= w_next_s;
            wr_cnt_r     <= cnt_next_s;
            drop_count_r <= drop_count_r + {6'd0, drop_add_s};
            if (release_s) begin
                bank_full_r[rd_bank_r] <= 1'b0;
                rd_bank_r              <= ~rd_bank_r;
                good_count_r           <= good_count_r + 8'd1;
            end
            if (commit_s) begin
                bank_full_r[wr_bank_r] <= 1'b1;
                bank_len_r[wr_bank_r]  <= cnt_next_s;
                wr_bank_r              <= ~wr_bank_r;
            end
        end
    end

    // Bank RAM write port, one byte lane per byte parity
    always_ff @(posedge clk_rx) begin
        if (mem_we_s) begin
            if (mem_idx_s[0]) begin
                mem_hi_r[{wr_bank_r, mem_idx_s[AW:1]}] <= rx_data;
            end else begin
                mem_lo_r[{wr_bank_r, mem_idx_s[AW:1]}] <= rx_data;
            end
        end
    end

    // Bank RAM read port with one cycle of latency
    always_ff @(posedge clk_rx) begin
        ram_lo_r <= mem_lo_r[{rd_bank_r, rd_word_s}];
        ram_hi_r <= mem_hi_r[{rd_bank_r, rd_word_s}];
    end

    // Read FSM next state; the RAM is always addressed one word ahead of the output register
    always_comb begin
        r_next_s    = r_state_r;
        rd_word_s   = '0;
        ld_idx_s    = '0;
        load_len_s  = 1'b0;
        load_word_s = 1'b0;
        release_s   = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (bank_full_r[rd_bank_r]) begin
                    load_len_s = 1'b1;
                    r_next_s   = R_LENGTH;
                end else begin
                    r_next_s   = R_IDLE;
                end
            end
            R_LENGTH: begin
                if (consume_s) begin
                    rd_word_s   = IDX_ONE;
                    load_word_s = 1'b1;
                    r_next_s    = R_DATA;
                end else begin
                    rd_word_s   = '0;
                end
            end
            R_DATA: begin
                if (consume_s) begin
                    if (idx_r == last_idx_r) begin
                        release_s = 1'b1;
                        r_next_s  = R_IDLE;
                    end else begin
                        rd_word_s   = idx_r + IDX_TWO;
                        ld_idx_s    = idx_r + IDX_ONE;
                        load_word_s = 1'b1;
                    end
                end else begin
                    rd_word_s = idx_r + IDX_ONE;
                end
            end
            default: begin
                r_next_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state and the registered FIFO word, which holds while the FIFO is full
    always_ff @(posedge clk_rx) begin
        if (reset) begin
            r_state_r    <= R_IDLE;
            word_ready_r <= 1'b0;
            wr_data_r    <= 16'h0000;
            idx_r        <= '0;
            last_idx_r   <= '0;
            rd_odd_r     <= 1'b0;
        end else begin
            r_state_r <= r_next_s;
            if (load_len_s) begin
                wr_data_r    <= {{(16-LEN_WIDTH){1'b0}}, bank_len_r[rd_bank_r][LEN_WIDTH-1:0]};
                word_ready_r <= 1'b1;
                rd_odd_r     <= bank_len_r[rd_bank_r][0];
                last_idx_r   <= nwords_s - IDX_ONE;
            end else if (load_word_s) begin
                // odd-length frames carry stale lane data above the final byte
                wr_data_r <= {((ld_idx_s == last_idx_r) && rd_odd_r) ? 8'h00 : ram_hi_r, ram_lo_r};
                idx_r     <= ld_idx_s;
            end else if (release_s) begin
                word_ready_r <= 1'b0;
            end
        end
    end

endmodule
